serial_add_ctrl: RTL

- Bit-serial adder controller: one time-shared FullAdder adds two WIDTH-bit operands, one bit per clock, LSB first.
- Owns the operand/result shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake.
- Used where area matters more than latency. It is the sequencing alternative to the parallel ripple-carry adder.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_ctrl_full_adder.sv | 19 +
 rtl/serial_add_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared state encodings and default width for the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

   localparam int SERIAL_ADD_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_full_adder
// Purpose  : One-bit full adder, the time-shared datapath of the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule : serial_add_ctrl_full_adder
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial adder controller, LSB first, one bit per clock.
//            Optional subtract mode enabled by macro SERIAL_ADD_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int               CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic [WIDTH-1:0] w_load_b;
   logic             w_load_c;
   logic             w_fa_sum;
   logic             w_fa_cout;

`ifdef SERIAL_ADD_SUB_EN
   // a - b computed as a + ~b + 1; cout=1 then means no borrow
   assign w_load_b = sub ? ~b : b;
   assign w_load_c = sub ? 1'b1 : cin;
`else
   assign w_load_b = b;
   assign w_load_c = cin;
`endif

   serial_add_ctrl_full_adder u_fa (
      .a  (sa_q[0]),
      .b  (sb_q[0]),
      .ci (carry_q),
      .s  (w_fa_sum),
      .co (w_fa_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = w_load_b;
               carry_d = w_load_c;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d   = {w_fa_sum, res_q[WIDTH-1:1]};
            carry_d = w_fa_cout;
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == c_last_bit) begin
               cout_d  = w_fa_cout;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // A start seen here chains straight into the next operation,
            // giving one result every WIDTH+1 cycles with start held high.
            if (start) begin
               sa_d    = a;
               sb_d    = w_load_b;
               carry_d = w_load_c;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign sum  = res_q;
   assign cout = cout_q;

endmodule : serial_add_ctrl
`default_nettype wire
